// File: rtl/aes_mixcolumns_seq.sv
// aes_mixcolumns_seq: iterative AES MixColumns / InvMixColumns unit.
// Transforms COLS_PER_CYCLE columns per clock (1, 2 or 4). valid/ready
// handshakes sit on both the input and the output side.
// Optional macro AES_MXC_OVERLAP_EN: in DONE, a result can retire and the
// next block can be accepted on the same edge.
module aes_mixcolumns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         inv_i,
    input  logic [127:0] mxc_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] mxc_o,
    output logic         busy
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("aes_mixcolumns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // With 4 columns per cycle this step wraps to 0, so col_cnt stays at 0.
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);

    state_t       state_q;
    state_t       state_d;
    logic [127:0] work_q;
    logic [127:0] work_next;
    logic         mode_q;
    logic [1:0]   col_cnt;
    logic         last_step;
    logic         load;

    // GF(2^8) multiply by 2 with reduction polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One column through the forward or inverse matrix. All constant
    // multiplies are built from the x2/x4/x8 xtime chain.
    function automatic logic [31:0] mix_column(input logic [31:0] col, input logic inv);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m3 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [31:0] res;
        res = '0;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m3[i] = x2[i] ^ a[i];
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        for (int r = 0; r < 4; r++) begin
            if (inv) begin
                res[31-8*r -: 8] = me[2'(r)] ^ mb[2'(r + 1)] ^ md[2'(r + 2)] ^ m9[2'(r + 3)];
            end else begin
                res[31-8*r -: 8] = x2[2'(r)] ^ m3[2'(r + 1)] ^ a[2'(r + 2)] ^ a[2'(r + 3)];
            end
        end
        return res;
    endfunction

    // Working register with the current group of columns transformed in place.
    always_comb begin
        work_next = work_q;
        last_step = (int'(col_cnt) + COLS_PER_CYCLE) >= 4;
        for (int k = 0; k < 4; k++) begin
            if (k >= int'(col_cnt) && k < int'(col_cnt) + COLS_PER_CYCLE) begin
                work_next[127-32*k -: 32] = mix_column(work_q[127-32*k -: 32], mode_q);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus handshake outputs and the block-load strobe.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                busy     = 1'b0;
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
`ifdef AES_MXC_OVERLAP_EN
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        load    = 1'b1;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
`else
                if (out_ready) begin
                    state_d = IDLE;
                end
`endif
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: load on accept, step columns in RUN, publish the result on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q  <= '0;
            mode_q  <= 1'b0;
            col_cnt <= 2'd0;
            mxc_o   <= '0;
        end else if (load) begin
            work_q  <= mxc_i;
            mode_q  <= inv_i;
            col_cnt <= 2'd0;
        end else if (state_q == RUN) begin
            work_q  <= work_next;
            col_cnt <= col_cnt + COL_STEP;
            if (last_step) begin
                mxc_o <= work_next;
            end
        end
    end

endmodule

// File: doc/aes_mixcolumns_seq.md
Name: aes_mixcolumns_seq

Overview:
Iterative AES MixColumns / InvMixColumns unit with a runtime direction select and a valid/ready handshake on both sides. It processes COLS_PER_CYCLE state columns per clock and trades area against latency. It sits between ShiftRows and AddRoundKey in the round datapath of the multi-cycle AES core, and serves both the encrypt and decrypt paths.

Parameters:
COLS_PER_CYCLE, 1, columns transformed per clock; legal values 1, 2, 4; any other value is an elaboration error.

Ports:
clk  input  1  clock; all state changes on the rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  upstream has a state block on mxc_i
in_ready  output  1  unit can accept a block
inv_i  input  1  direction, sampled with the block: 0 = MixColumns, 1 = InvMixColumns
mxc_i  input  128  input state; column k = mxc_i[127-32k -: 32]; row 0 is the top byte of each column
out_valid  output  1  mxc_o holds a finished result
out_ready  input  1  downstream accepts the result
mxc_o  output  128  result state, same byte layout as mxc_i
busy  output  1  high in RUN and DONE

Behaviour:
- Reset (async assert, sync release): state = IDLE. in_ready = 1, out_valid = 0, busy = 0, mxc_o = 0, column counter = 0, latched mode = 0.
- FSM states:
  - IDLE: in_ready = 1. On in_valid & in_ready, latch mxc_i into the working register and latch inv_i; go to RUN with col_cnt = 0.
  - RUN: in_ready = 0. Each cycle, transform columns col_cnt .. col_cnt+COLS_PER_CYCLE-1 in place, then advance col_cnt by COLS_PER_CYCLE. After the cycle that transforms column 3, go to DONE.
  - DONE: out_valid = 1 and mxc_o = working register. On out_ready, go to IDLE.
- Latency: with the accept edge at T, out_valid rises after edge T + 4/COLS_PER_CYCLE.
  - COLS_PER_CYCLE = 4: 1 cycle. COLS_PER_CYCLE = 1: 4 cycles.
- Throughput without the optional feature: one block per 4/COLS_PER_CYCLE + 2 cycles.
- Column arithmetic is over GF(2^8) with reduction polynomial 0x11B. For a column (a0, a1, a2, a3):
  - Forward matrix rows: [02 03 01 01], [01 02 03 01], [01 01 02 03], [03 01 01 02].
  - Inverse matrix rows: [0e 0b 0d 09], [09 0e 0b 0d], [0d 09 0e 0b], [0b 0d 09 0e].
  - Build the constant multiplies from xtime chains; no multipliers, no lookup tables.
- mxc_o holds its last value in IDLE and RUN and only updates on entry to DONE. out_valid stays high until out_ready, with mxc_o stable the whole time.
- inv_i and mxc_i are ignored outside the accept cycle; changing them mid-RUN has no effect.
- in_valid while busy: not accepted; the upstream must hold the block.
- rst_n asserted mid-RUN or in DONE: immediate return to reset values; the partial result is discarded and out_valid drops asynchronously.
- COLS_PER_CYCLE = 4: RUN lasts exactly one cycle and col_cnt stays 0.

Optional Feature:
Macro AES_MXC_OVERLAP_EN.
- Defined:
  - In DONE, in_ready = out_ready. A simultaneous out_ready & in_valid retires the result and accepts the next block on the same edge, going straight to RUN.
  - Back-to-back throughput becomes one block per 4/COLS_PER_CYCLE + 1 cycles.
  - busy stays high across the overlap.
- Undefined: in_ready = 1 only in IDLE, as described above.

Test Plan:
- Reset: hold rst_n = 0 with random inputs -> in_ready = 1, out_valid = 0, busy = 0, mxc_o = 0.
- Forward FIPS-197 vector: inv_i = 0, mxc_i = d4bf5d30e0b452aeb84111f11e2798e5, out_ready = 1 -> mxc_o = 046681e5e0cb199a48f8d37a2806264c. out_valid rises exactly 4/COLS_PER_CYCLE cycles after accept; run with COLS_PER_CYCLE = 1, 2 and 4.
- Inverse vector: inv_i = 1, mxc_i = 046681e5e0cb199a48f8d37a2806264c -> mxc_o = d4bf5d30e0b452aeb84111f11e2798e5. Also check single columns: db135345 -> 8e4da1bc forward; 01010101 and c6c6c6c6 unchanged in both modes.
- Backpressure: out_ready = 0 for 10 cycles after out_valid -> mxc_o stable, in_ready = 0, a new in_valid is not accepted. Then raise out_ready -> one-cycle retire, back to IDLE.
- Reset mid-RUN (COLS_PER_CYCLE = 1): assert rst_n = 0 after 2 RUN cycles -> outputs at reset values immediately. A following block with inv_i = 0 and a known vector then produces the correct result.
- With AES_MXC_OVERLAP_EN: stream 3 forward/inverse alternating blocks with out_ready = 1 held -> out_valid pulses spaced 4/COLS_PER_CYCLE + 1 cycles apart, each result correct for its latched mode. Without the macro, the spacing is +2.
